axi_lite_fetch_master: RTL and testbench

Single-outstanding AXI4-Lite read initiator that turns core instruction-fetch requests into AR/R transactions against the testbench AXI-Lite memory (64-bit R channel, instruction word in bits [31:0]). Sits between the fetch stage and the memory port. Provides alignment checking, a response-timeout watchdog, pipeline-flush discard and a one-entry response holding buffer, so the core can apply backpressure.

---
 rtl/axi_lite_fetch_master_if.sv | 23 ++
 rtl/axi_lite_fetch_master.sv | 154 +++++++++++++++
 tb/tb_axi_lite_fetch_master.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_fetch_master_if.sv
// AXI4-Lite read-only channel bundle (AR + R) between the fetch master and memory.
// The R channel is 64 bits wide; the fetch master only uses the low word.
interface axi_lite_fetch_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_fetch_master.sv
// Single-outstanding AXI4-Lite instruction-fetch read initiator with alignment check,
// R-beat watchdog, flush discard and a one-entry response holding buffer.
module axi_lite_fetch_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   req_ready,
  input  logic                   flush,
  output logic                   resp_valid,
  output logic [31:0]            resp_data,
  output logic [1:0]             resp_err,
  input  logic                   resp_ready,
  axi_lite_fetch_master_if.master bus
);

  localparam int unsigned          TMR_W       = 16;
  localparam logic [TMR_W-1:0]     TMR_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [1:0]           ERR_ALIGN   = 2'b10;
  localparam logic [1:0]           ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t            state;
  logic              stale;
  logic              discard;
  logic [TMR_W-1:0]  timer;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              rready_q;
  logic              stale_done;
  logic              misaligned;
  logic              unused_rdata_hi;

  assign bus.arvalid = arvalid_q;
  assign bus.araddr  = araddr_q;
  assign bus.rready  = rready_q;

  // Orphaned beat absorbed, or gave up waiting for it.
  assign stale_done      = stale && (bus.rvalid || (timer == TMR_LAST));
  assign misaligned      = (req_addr[1:0] != 2'b00);
  assign unused_rdata_hi = ^bus.rdata[63:32];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      stale      <= 1'b0;
      discard    <= 1'b0;
      timer      <= '0;
      req_ready  <= 1'b1;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (stale) begin
            if (stale_done) begin
              stale     <= 1'b0;
              rready_q  <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end else if (req_valid && req_ready && !flush) begin
            req_ready <= 1'b0;
            if (misaligned) begin
              state      <= HOLD;
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_err   <= ERR_ALIGN;
            end else begin
              state     <= ADDR;
              arvalid_q <= 1'b1;
              araddr_q  <= req_addr;
            end
          end
        end

        // AR is never retracted; a flush here only marks the beat for discard.
        ADDR: begin
          if (flush) discard <= 1'b1;
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            timer     <= '0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end

        DATA: begin
          if (bus.rvalid) begin
            discard  <= 1'b0;
            rready_q <= 1'b0;
            if (discard || flush) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end else begin
              state      <= HOLD;
              resp_valid <= 1'b1;
              resp_data  <= bus.rdata[31:0];
              resp_err   <= bus.rresp;
            end
          end else if (flush) begin
            state   <= IDLE;
            stale   <= 1'b1;
            discard <= 1'b0;
            timer   <= '0;
          end else if (timer == TMR_LAST) begin
            stale   <= 1'b1;
            discard <= 1'b0;
            timer   <= '0;
            if (discard) begin
              state <= IDLE;
            end else begin
              state      <= HOLD;
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_err   <= ERR_TIMEOUT;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // rready stays up while stale so a late beat can be absorbed during HOLD.
        HOLD: begin
          if (stale) begin
            if (stale_done) begin
              stale    <= 1'b0;
              rready_q <= 1'b0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          if (flush || resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= !stale || stale_done;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_fetch_master.sv
// Directed bench for axi_lite_fetch_master with a scripted AXI-Lite memory responder.
module tb_axi_lite_fetch_master;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic        resp_ready;

  axi_lite_fetch_master_if #(.ADDR_W(32)) bus ();

  axi_lite_fetch_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .bus        (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:7];
  logic        auto_mem;
  logic [1:0]  resp_code;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; the auto memory answers one cycle after an AR handshake.
  task automatic step();
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] ar_addr;
    ar_hs   = bus.arvalid && bus.arready;
    r_hs    = bus.rvalid && bus.rready;
    ar_addr = bus.araddr;
    @(posedge CLK);
    #1;
    if (auto_mem) begin
      if (r_hs) bus.rvalid = 1'b0;
      if (ar_hs) begin
        bus.rvalid = 1'b1;
        bus.rdata  = {32'hDEADBEEF, mem[ar_addr[4:2]]};
        bus.rresp  = resp_code;
      end
    end
  endtask

  // Issue a fetch and wait (bounded) for resp_valid; lat counts edges from accept.
  task automatic fetch(input logic [31:0] addr, output int lat);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
    end
    check("fetch_bound", 64'(resp_valid), 64'd1);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  int lat;
  int n;

  initial begin
    mem[0] = 32'h00000013; mem[1] = 32'h00100093; mem[2] = 32'h00200113; mem[3] = 32'h00300193;
    mem[4] = 32'h00400213; mem[5] = 32'h00500293; mem[6] = 32'h00600313; mem[7] = 32'h00700393;
    auto_mem    = 1'b1;
    resp_code   = 2'b00;
    RST         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    flush       = 1'b0;
    resp_ready  = 1'b0;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    step();
    step();
    RST = 1'b0;
    step();

    // reset values
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_arvalid", 64'(bus.arvalid), 64'd0);
    check("rst_araddr", 64'(bus.araddr), 64'd0);
    check("rst_rready", 64'(bus.rready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);

    // normal fetch with cycle-by-cycle timing
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    req_valid = 1'b0;
    check("nf_c1_arvalid", 64'(bus.arvalid), 64'd1);
    check("nf_c1_araddr", 64'(bus.araddr), 64'h0);
    check("nf_c1_req_ready", 64'(req_ready), 64'd0);
    step();
    check("nf_c2_arvalid", 64'(bus.arvalid), 64'd0);
    check("nf_c2_rready", 64'(bus.rready), 64'd1);
    check("nf_c2_resp_valid", 64'(resp_valid), 64'd0);
    step();
    check("nf_c3_resp_valid", 64'(resp_valid), 64'd1);
    check("nf_c3_resp_data", 64'(resp_data), 64'h00000013);
    check("nf_c3_resp_err", 64'(resp_err), 64'd0);
    check("nf_c3_rready", 64'(bus.rready), 64'd0);

    // backpressure: response held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_resp_data", 64'(resp_data), 64'h00000013);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    consume();
    check("bp_done_resp_valid", 64'(resp_valid), 64'd0);
    check("bp_done_req_ready", 64'(req_ready), 64'd1);

    // forwarded SLVERR response and best-case latency
    resp_code = 2'b10;
    fetch(32'h8, lat);
    check("slverr_lat", 64'(lat), 64'd3);
    check("slverr_data", 64'(resp_data), 64'h00200113);
    check("slverr_err", 64'(resp_err), 64'd2);
    consume();
    resp_code = 2'b00;

    // misaligned request: no bus access, error next cycle
    req_valid = 1'b1;
    req_addr  = 32'h6;
    step();
    req_valid = 1'b0;
    check("mis_arvalid", 64'(bus.arvalid), 64'd0);
    check("mis_resp_valid", 64'(resp_valid), 64'd1);
    check("mis_resp_err", 64'(resp_err), 64'd2);
    check("mis_resp_data", 64'(resp_data), 64'd0);
    consume();
    check("mis_req_ready", 64'(req_ready), 64'd1);

    // timeout, then late beat is absorbed
    auto_mem  = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    step();
    req_valid = 1'b0;
    check("to_arvalid", 64'(bus.arvalid), 64'd1);
    n = 0;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    check("to_cycles", 64'(n), 64'd9);
    check("to_resp_err", 64'(resp_err), 64'd3);
    check("to_resp_data", 64'(resp_data), 64'd0);
    check("to_stale_rready", 64'(bus.rready), 64'd1);
    consume();
    check("to_consumed_valid", 64'(resp_valid), 64'd0);
    check("to_stale_req_ready", 64'(req_ready), 64'd0);
    bus.rvalid = 1'b1;
    bus.rdata  = 64'h0000_0000_BAD0_BAD0;
    step();
    bus.rvalid = 1'b0;
    check("to_late_req_ready", 64'(req_ready), 64'd1);
    check("to_late_rready", 64'(bus.rready), 64'd0);
    check("to_late_resp_valid", 64'(resp_valid), 64'd0);

    // timeout with no late beat: stale expires after TIMEOUT cycles
    req_valid = 1'b1;
    req_addr  = 32'h14;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
    check("to2_cycles", 64'(n), 64'd9);
    consume();
    n = 0;
    while (!req_ready && n < 40) begin
      step();
      n++;
    end
    check("to2_stale_expiry", 64'(n), 64'd7);
    check("to2_rready", 64'(bus.rready), 64'd0);

    // flush in DATA; the next-cycle beat is swallowed
    req_valid = 1'b1;
    req_addr  = 32'h8;
    step();
    req_valid = 1'b0;
    step();
    check("fd_rready", 64'(bus.rready), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fd_resp_valid", 64'(resp_valid), 64'd0);
    check("fd_req_ready", 64'(req_ready), 64'd0);
    check("fd_stale_rready", 64'(bus.rready), 64'd1);
    bus.rvalid = 1'b1;
    bus.rdata  = 64'h0000_0000_BAD0_BAD0;
    step();
    bus.rvalid = 1'b0;
    check("fd_swallow_valid", 64'(resp_valid), 64'd0);
    check("fd_swallow_req_ready", 64'(req_ready), 64'd1);
    auto_mem = 1'b1;
    fetch(32'h4, lat);
    check("fd_next_lat", 64'(lat), 64'd3);
    check("fd_next_data", 64'(resp_data), 64'h00100093);
    check("fd_next_err", 64'(resp_err), 64'd0);
    consume();

    // flush in ADDR: AR completes, beat dropped silently
    bus.arready = 1'b0;
    req_valid   = 1'b1;
    req_addr    = 32'h8;
    step();
    req_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    check("fa_arvalid_held", 64'(bus.arvalid), 64'd1);
    check("fa_araddr_held", 64'(bus.araddr), 64'h8);
    bus.arready = 1'b1;
    step();
    check("fa_data_rready", 64'(bus.rready), 64'd1);
    step();
    check("fa_resp_valid", 64'(resp_valid), 64'd0);
    check("fa_req_ready", 64'(req_ready), 64'd1);
    step();
    check("fa_quiet_valid", 64'(resp_valid), 64'd0);

    // flush in HOLD drops the response
    fetch(32'hC, lat);
    check("fh_data", 64'(resp_data), 64'h00300193);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fh_resp_valid", 64'(resp_valid), 64'd0);
    check("fh_req_ready", 64'(req_ready), 64'd1);

    // flush wins over a simultaneous request in IDLE
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("fi_arvalid", 64'(bus.arvalid), 64'd0);
    check("fi_req_ready", 64'(req_ready), 64'd1);

    // reset while AR is pending
    bus.arready = 1'b0;
    req_valid   = 1'b1;
    req_addr    = 32'h10;
    step();
    req_valid = 1'b0;
    check("rm_arvalid_pre", 64'(bus.arvalid), 64'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rm_arvalid", 64'(bus.arvalid), 64'd0);
    check("rm_req_ready", 64'(req_ready), 64'd1);
    check("rm_resp_valid", 64'(resp_valid), 64'd0);
    check("rm_rready", 64'(bus.rready), 64'd0);
    bus.arready = 1'b1;
    auto_mem    = 1'b0;
    bus.rvalid  = 1'b1;
    step();
    bus.rvalid = 1'b0;
    check("rm_late_resp_valid", 64'(resp_valid), 64'd0);
    check("rm_late_req_ready", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
